gen_toggle_collector: RTL and testbench
=======================================

GEN_TOGGLE_COLLECTOR -- requirements
Module: gen_toggle_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 39: number of toggle points monitored by this instance.
REQ-002 SHALL have parameter COVER_INDEX, default 0: global index of bit 0 of valid.
REQ-003 SHALL have parameter COVER_TOTAL, default 8940: global point count, for reporting only; no function depends on it.
REQ-004 SHALL have parameter IDX_W, default 32: width of out_index.
REQ-005 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port valid, input, WIDTH: per-point toggle event in the current cycle.
REQ-008 SHALL have port enable, input, 1: when 0, valid is ignored.
REQ-009 SHALL have port clear, input, 1: synchronous clear of all coverage state.
REQ-010 SHALL have port out_valid, output, 1: a newly covered index is presented.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts out_index.
REQ-012 SHALL have port out_index, output, IDX_W: COVER_INDEX + local bit number of the presented point.
REQ-013 SHALL have port covered_count, output, $clog2(WIDTH+1): number of points hit so far.
REQ-014 SHALL have port all_covered, output, 1: covered_count == WIDTH.

Function
REQ-015 SHALL keep a sticky hit[WIDTH] register; hit[i] is set at the edge where enable=1, valid[i]=1 and clear=0, and is never set otherwise.
REQ-016 SHALL set pending[i] at the same edge as hit[i], but only on the first hit (hit[i] was 0); repeat hits SHALL have no effect.
REQ-017 SHALL hold the output in a one-entry slot (out_valid, out_index); slot state is EMPTY (out_valid=0) or FULL (out_valid=1).
REQ-018 SHALL treat the slot as free at an edge when it is EMPTY, or when it is FULL and out_valid & out_ready.
REQ-019 SHALL, at an edge where the slot is free, load the lowest-numbered set bit of the registered pending vector into the slot and clear that pending bit; the vector used is the value before this edge's new hits.
REQ-020 SHALL, at an edge where the slot is free and pending is all-zero, go to EMPTY.
REQ-021 SHALL keep out_index and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL sustain one accepted index per cycle when out_ready is held high and pending is non-empty.
REQ-023 SHALL emit each local index at most once between clears.
REQ-024 SHALL give a new-hit latency as follows: valid[i] in cycle N with slot EMPTY and no other pending points means out_valid=1 with that index in cycle N+2.
REQ-025 SHALL register covered_count as the population count of hit; it reflects hit one cycle later, so it is visible in cycle N+2.
REQ-026 SHALL allow multiple points to be newly hit in the same cycle; all are recorded, and the count increases by their number.
REQ-027 SHALL give clear priority over valid and the handshake: at a clear edge, hit, pending, slot and covered_count go to 0, and any same-cycle valid or acceptance is discarded.
REQ-028 SHALL compute out_index as zero-extended local index plus COVER_INDEX, modulo 2^IDX_W.

Reset
REQ-029 SHALL, while reset=1 (asynchronous), force hit=0, pending=0, out_valid=0, out_index=0, covered_count=0 and all_covered=0.
REQ-030 SHALL ignore valid and out_ready during reset; the first edge after reset deasserts is a normal cycle.
REQ-031 SHALL apply the reset values of REQ-029 when reset asserts mid-handshake; the presented index is lost and is not re-emitted.

Verification (WIDTH=39, COVER_INDEX=100)
REQ-032 SHALL cover this case: valid=bit5 for one cycle at N, out_ready=1 -> out_valid=1, out_index=105 in cycle N+2 only; covered_count=1 from N+2.
REQ-033 SHALL cover this case: valid=bits{3,7,38} in one cycle, out_ready=1 -> indices 103, 107, 138 on consecutive cycles; covered_count=3.
REQ-034 SHALL cover this case: out_ready=0 with index 103 presented, then valid=bit1 -> out_index stays 103 until accepted, then 101 follows.
REQ-035 SHALL cover this case: valid=bit5 repeatedly over 10 cycles -> exactly one emission of 105; covered_count=1.
REQ-036 SHALL cover this case: all 39 bits hit with enable=1 -> all_covered=1 and 39 distinct indices 100..138 in ascending order; with enable=0 -> no emission.
REQ-037 SHALL cover this case: clear asserted together with valid=bit2 while 104 is pending -> nothing emitted, count=0; bit2 hit afterwards -> 102 emitted.

Source files
------------

// File: rtl/gen_toggle_collector.sv
// Sticky toggle-coverage collector: records first hits per point and streams each newly covered global index once.
// Latency: valid[i] -> out_valid two cycles later; backpressure via out_valid/out_ready, pending hits queue in a bitmap.
module gen_toggle_collector #(
    parameter int WIDTH       = 39,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 8940,
    parameter int IDX_W       = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             valid,
    input  logic                         enable,
    input  logic                         clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_index,
    output logic [$clog2(WIDTH+1)-1:0]   covered_count,
    output logic                         all_covered
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int LIDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // A slice that does not fit inside the global point space is a wiring mistake.
    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
        $error("gen_toggle_collector: slice exceeds COVER_TOTAL");
    end

    logic [WIDTH-1:0]  hit;
    logic [WIDTH-1:0]  pending;
    logic [WIDTH-1:0]  new_hit;
    logic [WIDTH-1:0]  take_mask;
    logic              slot_free;
    logic              pend_any;
    logic [LIDX_W-1:0] pend_idx;
    logic [CNT_W-1:0]  hit_pop;

    assign new_hit   = {WIDTH{enable}} & valid & ~hit;
    assign slot_free = !out_valid || out_ready;

    // Lowest-numbered pending point wins the slot.
    always_comb begin
        pend_any  = 1'b0;
        pend_idx  = '0;
        take_mask = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pend_any = 1'b1;
                pend_idx = LIDX_W'(i);
            end
        end
        if (slot_free && pend_any) begin
            take_mask[pend_idx] = 1'b1;
        end
    end

    always_comb begin
        hit_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hit_pop = hit_pop + CNT_W'(hit[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit           <= '0;
            pending       <= '0;
            out_valid     <= 1'b0;
            out_index     <= '0;
            covered_count <= '0;
        end else if (clear) begin
            hit           <= '0;
            pending       <= '0;
            out_valid     <= 1'b0;
            out_index     <= '0;
            covered_count <= '0;
        end else begin
            hit           <= hit | new_hit;
            // A point being loaded is already hit, so it never collides with new_hit.
            pending       <= (pending & ~take_mask) | new_hit;
            covered_count <= hit_pop;
            if (slot_free) begin
                out_valid <= pend_any;
                if (pend_any) begin
                    out_index <= IDX_W'(COVER_INDEX) + IDX_W'(pend_idx);
                end
            end
        end
    end

    assign all_covered = (covered_count == CNT_W'(WIDTH));

endmodule

// File: tb/tb_gen_toggle_collector.sv
// Randomized and directed bench for gen_toggle_collector (WIDTH=39, COVER_INDEX=100) against a queue/array model.
module tb_gen_toggle_collector;

    localparam int W    = 39;
    localparam int BASE = 100;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  valid = '0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_index;
    logic [5:0]    covered_count;
    logic          all_covered;

    int checks = 0;
    int errors = 0;

    gen_toggle_collector #(.WIDTH(W), .COVER_INDEX(BASE), .COVER_TOTAL(8940), .IDX_W(32)) dut (
        .clock(clock), .reset(reset), .valid(valid), .enable(enable), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .covered_count(covered_count), .all_covered(all_covered)
    );

    always #5 clock = ~clock;

    // Reference model: which points were ever hit, which still await emission, what the slot shows.
    bit m_hit [W];
    bit m_pend[W];
    bit m_sv;
    int m_si;
    int m_cnt;
    int acc[$];

    function automatic int popc();
        int n = 0;
        for (int i = 0; i < W; i++) n += m_hit[i];
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_hit[i]  = 0;
            m_pend[i] = 0;
        end
        m_sv = 0; m_si = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic [W-1:0] v, input logic en, input logic clr, input logic rdy);
        int old = popc();
        int low = -1;
        if (clr) begin
            model_reset();
            return;
        end
        if (!m_sv || rdy) begin
            for (int i = W - 1; i >= 0; i--) if (m_pend[i]) low = i;
            if (low >= 0) begin
                m_sv = 1; m_si = BASE + low; m_pend[low] = 0;
            end else begin
                m_sv = 0;
            end
        end
        for (int i = 0; i < W; i++) begin
            if (en && v[i] && !m_hit[i]) begin
                m_hit[i]  = 1;
                m_pend[i] = 1;
            end
        end
        m_cnt = old;
    endtask

    // Drive one cycle at the falling edge, log accepted indices, advance the model with the DUT.
    task automatic cycle(input logic [W-1:0] v, input logic en, input logic clr, input logic rdy);
        valid = v; enable = en; clear = clr; out_ready = rdy;
        if (out_valid && rdy && !clr) acc.push_back(int'(out_index));
        @(posedge clock);
        model_step(v, en, clr, rdy);
        @(negedge clock);
    endtask

    task automatic do_clear();
        cycle('0, 1'b1, 1'b1, 1'b0);
        acc.delete();
    endtask

    function automatic logic [W-1:0] bitm(input int b);
        logic [W-1:0] m = '0;
        m[b] = 1'b1;
        return m;
    endfunction

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || out_index !== 32'd0 || covered_count !== 6'd0 || all_covered !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b out_index=%0d count=%0d all=%b, required 0/0/0/0",
                     out_valid, out_index, covered_count, all_covered);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single_hit();
        do_clear();
        cycle(bitm(5), 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_n1_valid: got %b, required 0", out_valid);
        end
        cycle('0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 32'd105 || covered_count !== 6'd1) begin
            errors++;
            $display("FAIL single_n2: valid=%b index=%0d count=%0d, required 1/105/1", out_valid, out_index, covered_count);
        end
        cycle('0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || covered_count !== 6'd1) begin
            errors++; $display("FAIL single_n3: valid=%b count=%0d, required 0/1", out_valid, covered_count);
        end
    endtask

    task automatic test_multi_hit();
        int exp[3] = '{103, 107, 138};
        do_clear();
        cycle(bitm(3) | bitm(7) | bitm(38), 1'b1, 1'b0, 1'b1);
        cycle('0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_index !== 32'(exp[k])) begin
                errors++;
                $display("FAIL multi_seq%0d: valid=%b index=%0d, required 1/%0d", k, out_valid, out_index, exp[k]);
            end
            cycle('0, 1'b1, 1'b0, 1'b1);
        end
        checks++;
        if (out_valid !== 1'b0 || covered_count !== 6'd3) begin
            errors++; $display("FAIL multi_end: valid=%b count=%0d, required 0/3", out_valid, covered_count);
        end
    endtask

    task automatic test_backpressure();
        do_clear();
        cycle(bitm(3), 1'b1, 1'b0, 1'b0);
        cycle(bitm(1), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_index !== 32'd103) begin
                errors++; $display("FAIL stall_hold%0d: valid=%b index=%0d, required 1/103", k, out_valid, out_index);
            end
            cycle('0, 1'b1, 1'b0, 1'b0);
        end
        cycle('0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 32'd101) begin
            errors++; $display("FAIL stall_next: valid=%b index=%0d, required 1/101", out_valid, out_index);
        end
        cycle('0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (acc.size() != 2 || acc[0] != 103 || acc[1] != 101) begin
            errors++; $display("FAIL stall_order: accepted %0d items, required 103 then 101", acc.size());
        end
    endtask

    task automatic test_repeat();
        do_clear();
        repeat (10) cycle(bitm(5), 1'b1, 1'b0, 1'b1);
        repeat (3) cycle('0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (acc.size() != 1 || acc[0] != 105 || covered_count !== 6'd1) begin
            errors++; $display("FAIL repeat_once: emitted %0d count=%0d, required 1 emission of 105, count 1", acc.size(), covered_count);
        end
    endtask

    task automatic test_all_cover();
        logic [W-1:0] v;
        bit ok = 1;
        do_clear();
        for (int k = 0; k < 8; k++) begin
            v = {$urandom, $urandom};
            cycle(v, 1'b0, 1'b0, 1'b1);
        end
        repeat (2) cycle('0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (acc.size() != 0 || out_valid !== 1'b0 || covered_count !== 6'd0) begin
            errors++; $display("FAIL enable_off: emitted %0d count=%0d, required 0/0", acc.size(), covered_count);
        end
        cycle('1, 1'b1, 1'b0, 1'b1);
        repeat (42) cycle('0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < acc.size(); k++) if (acc[k] != BASE + k) ok = 0;
        checks++;
        if (acc.size() != W || !ok) begin
            errors++; $display("FAIL all_order: emitted %0d in order=%0d, required 39 ascending 100..138", acc.size(), ok);
        end
        checks++;
        if (all_covered !== 1'b1 || covered_count !== 6'd39) begin
            errors++; $display("FAIL all_covered: all=%b count=%0d, required 1/39", all_covered, covered_count);
        end
    endtask

    task automatic test_clear();
        do_clear();
        cycle(bitm(0), 1'b1, 1'b0, 1'b0);
        cycle(bitm(4), 1'b1, 1'b0, 1'b0);
        cycle(bitm(2), 1'b1, 1'b1, 1'b1);
        acc.delete();
        repeat (4) cycle('0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (acc.size() != 0 || covered_count !== 6'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL clear_discard: emitted %0d count=%0d, required 0/0", acc.size(), covered_count);
        end
        cycle(bitm(2), 1'b1, 1'b0, 1'b1);
        repeat (3) cycle('0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (acc.size() != 1 || acc[0] != 102) begin
            errors++; $display("FAIL clear_after: emitted %0d first=%0d, required 1 item 102", acc.size(), acc.size() ? acc[0] : -1);
        end
    endtask

    task automatic test_reset_mid_handshake();
        do_clear();
        cycle(bitm(9), 1'b1, 1'b0, 1'b0);
        cycle(bitm(10), 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_index !== 32'd0 || covered_count !== 6'd0 || all_covered !== 1'b0) begin
            errors++; $display("FAIL async_reset: valid=%b index=%0d count=%0d, required 0/0/0", out_valid, out_index, covered_count);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        acc.delete();
        repeat (5) cycle('0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (acc.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_lost: emitted %0d after reset, required 0", acc.size());
        end
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        do_clear();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < W; i++) v[i] = ($urandom_range(0, 24) == 0);
            cycle(v, $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0);
            checks++;
            if (out_valid !== m_sv || (m_sv && out_index !== 32'(m_si))) begin
                errors++; $display("FAIL rand_slot c%0d: valid=%b index=%0d, required %0d/%0d", c, out_valid, out_index, m_sv, m_si);
            end
            checks++;
            if (covered_count !== 6'(m_cnt) || all_covered !== (m_cnt == W)) begin
                errors++; $display("FAIL rand_count c%0d: count=%0d all=%b, required %0d/%0d", c, covered_count, all_covered, m_cnt, m_cnt == W);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_multi_hit();
        test_backpressure();
        test_repeat();
        test_all_cover();
        test_clear();
        test_reset_mid_handshake();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
